// File: rtl/aes_key_schedule_seq.sv
// AES-128 key schedule: one combinational expansion round per clock into an
// 11-entry round-key register file, served through a registered read port.

module aes_keyexpander128_comb (
    input  logic [127:0] prev_key,
    input  logic [3:0]   round,
    output logic [127:0] next_key
);
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = '0;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = xtime(x);
        end
        return acc;
    endfunction

    // Inverse as a^254 (maps 0 to 0), then the AES affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] inv;
        p   = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p   = gf_mul(p, p);
            inv = gf_mul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    logic [7:0]  rcon;
    logic [31:0] w0, w1, w2, w3, rot, sub, n0, n1, n2, n3;

    always_comb begin
        rcon = 8'h00;
        case (round)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign w0  = prev_key[127:96];
    assign w1  = prev_key[95:64];
    assign w2  = prev_key[63:32];
    assign w3  = prev_key[31:0];
    assign rot = {w3[23:0], w3[31:24]};
    assign sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    assign n0  = w0 ^ sub ^ {rcon, 24'h0};
    assign n1  = w1 ^ n0;
    assign n2  = w2 ^ n1;
    assign n3  = w3 ^ n2;
    assign next_key = {n0, n1, n2, n3};
endmodule

// Handshake: a key transfers on a rising edge where key_valid && key_ready;
// key_ready depends only on state, key_valid is ignored while key_ready is low.
module aes_key_schedule_seq (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] key,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk_out,
    output logic         busy,
    output logic         keys_valid,
    output logic [1:0]   state_dbg
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t       state, state_nxt;
    logic [127:0] rk [0:10];
    logic [3:0]   round;
    logic [127:0] prev_key, next_key, rd_data;
    logic         accept;

    aes_keyexpander128_comb u_expander (
        .prev_key (prev_key),
        .round    (round),
        .next_key (next_key)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        key_ready  = 1'b0;
        busy       = 1'b0;
        keys_valid = 1'b0;
        case (state)
            IDLE: begin
                key_ready = 1'b1;
                if (key_valid) state_nxt = EXPAND;
            end
            EXPAND: begin
                busy = 1'b1;
                if (round == 4'd10) state_nxt = DONE;
            end
            DONE: begin
                key_ready  = 1'b1;
                keys_valid = 1'b1;
                if (key_valid) state_nxt = EXPAND;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept    = key_valid && key_ready;
    assign state_dbg = state;

    // round is 0 outside EXPAND, so the expander then sees zero input.
    always_comb begin
        prev_key = '0;
        for (int i = 1; i <= 10; i++)
            if (round == 4'(i)) prev_key = rk[i-1];
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i <= 10; i++)
            if (rk_idx == 4'(i)) rd_data = rk[i];
    end

    // rk_out samples pre-edge contents, so a same-edge write is not bypassed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            round  <= '0;
            rk_out <= '0;
            for (int i = 0; i <= 10; i++) rk[i] <= '0;
        end else begin
            rk_out <= rd_data;
            if (accept) begin
                rk[0] <= key;
                round <= 4'd1;
            end else if (state == EXPAND) begin
                for (int i = 1; i <= 10; i++)
                    if (round == 4'(i)) rk[i] <= next_key;
                round <= (round == 4'd10) ? 4'd0 : round + 4'd1;
            end
        end
    end
endmodule
